// File: rtl/grf_scoreboard.sv
// Two-write-port register file with a per-register pending-write scoreboard.
// Optional write trace enabled by defining GRF_TRACE_EN.
module grf_scoreboard #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic [31:0]   pc0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic [31:0]   pc1,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    output logic [AW:0]   pend_cnt
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_next;
    logic            wr0;
    logic            wr1;
    logic            iss_wr_hit;
    logic            iss_take;

    // r0 is hardwired: writes to address 0 never count as writes
    assign wr0 = we0 && (wa0 != '0);
    assign wr1 = we1 && (wa1 != '0);

    assign iss_wr_hit = (wr0 && (wa0 == iss_rd)) || (wr1 && (wa1 == iss_rd));
    assign iss_ready  = reset && !(busy[iss_rd] && !iss_wr_hit);
    assign iss_take   = iss_valid && iss_ready && (iss_rd != '0);

    // Completion clears first so a same-cycle issue to that register wins
    always_comb begin
        busy_next = busy;
        if (wr0) busy_next[wa0] = 1'b0;
        if (wr1) busy_next[wa1] = 1'b0;
        if (iss_take) busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + (AW+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_next;
            pend_cnt <= cnt_next;
        end
    end

    // Port 1 assigned last so it takes priority on an address collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0) regs[wa0] <= wd0;
            if (wr1) regs[wa1] <= wd1;
        end
    end

    always_comb begin
        rd1   = regs[ra1];
        busy1 = busy[ra1];
        if (reset && wr1 && (wa1 == ra1)) begin
            rd1   = wd1;
            busy1 = 1'b0;
        end else if (reset && wr0 && (wa0 == ra1)) begin
            rd1   = wd0;
            busy1 = 1'b0;
        end
    end

    always_comb begin
        rd2   = regs[ra2];
        busy2 = busy[ra2];
        if (reset && wr1 && (wa1 == ra2)) begin
            rd2   = wd1;
            busy2 = 1'b0;
        end else if (reset && wr0 && (wa0 == ra2)) begin
            rd2   = wd0;
            busy2 = 1'b0;
        end
    end

`ifdef GRF_TRACE_EN
    // Port 0 prints first; a write later overridden by port 1 still shows
    always @(posedge clk) begin
        if (reset) begin
            if (wr0) $display("%d@%h: $%d <= %h", $time, pc0, wa0, wd0);
            if (wr1) $display("%d@%h: $%d <= %h", $time, pc1, wa1, wd1);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{pc0, pc1};
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomised scoreboard bench for grf_scoreboard: expectations queued by the
// stimulus process, popped and compared by an independent monitor.
module tb_grf_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [31:0]   pc0, pc1;
    logic [AW-1:0] ra1, ra2;
    logic [DW-1:0] rd1, rd2;
    logic          busy1, busy2;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_ready;
    logic [AW:0]   pend_cnt;

    grf_scoreboard #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        rdy;
        logic [5:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: register contents and pending flags
    logic [31:0] m_mem  [NREG];
    bit          m_busy [NREG];

    function automatic bit writes(input int a, input int p);
        if (p == 0) return we0 && wa0 == a[AW-1:0] && a != 0;
        return we1 && wa1 == a[AW-1:0] && a != 0;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (reset && writes(a, 1)) return wd1;
        if (reset && writes(a, 0)) return wd0;
        return m_mem[a];
    endfunction

    function automatic bit m_busy_out(input int a);
        if (reset && (writes(a, 0) || writes(a, 1))) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit m_ready();
        int d = int'(iss_rd);
        if (!reset) return 1'b0;
        return !(m_busy[d] && !(writes(d, 0) || writes(d, 1)));
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic step(input bit chk, input string tag);
        exp_t e;
        bit   rdy;
        rdy = m_ready();
        if (chk) begin
            e.tag = tag;
            e.rd1 = m_read(int'(ra1));
            e.rd2 = m_read(int'(ra2));
            e.b1  = m_busy_out(int'(ra1));
            e.b2  = m_busy_out(int'(ra2));
            e.rdy = rdy;
            e.cnt = 6'(m_count());
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
            if (iss_valid && rdy && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        iss_valid = 0; iss_rd = 0; ra1 = 0; ra2 = 0;
    endtask

    task automatic cmp(input string tag, input string f, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, f, act, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.tag, "rd1", rd1, e.rd1);
                cmp(e.tag, "rd2", rd2, e.rd2);
                cmp(e.tag, "busy1", 32'(busy1), 32'(e.b1));
                cmp(e.tag, "busy2", 32'(busy2), 32'(e.b2));
                cmp(e.tag, "iss_ready", 32'(iss_ready), 32'(e.rdy));
                cmp(e.tag, "pend_cnt", 32'(pend_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        int wait_cyc;
        pc0 = 32'h1000; pc1 = 32'h2000;
        idle();
        reset = 1'b0;
        step(0, "init_reset");
        idle();

        ra1 = 3; step(1, "after_reset");

        idle(); we0 = 1; wa0 = 5; wd0 = 32'hA5A5A5A5; ra1 = 5; step(1, "bypass_p0");
        idle(); ra1 = 5; step(1, "stored_r5");

        idle(); we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 1; wd1 = 2; ra2 = 7;
        step(1, "collide_bypass");
        idle(); ra1 = 7; step(1, "collide_stored");

        idle(); iss_valid = 1; iss_rd = 9; step(1, "issue9");
        idle(); ra1 = 9; iss_valid = 1; iss_rd = 9; step(1, "waw_stall");
        idle(); ra1 = 9; iss_valid = 1; iss_rd = 9; we1 = 1; wa1 = 9; wd1 = 32'h99;
        step(1, "waw_with_write");
        idle(); ra1 = 9; step(1, "set_wins");

        idle(); we0 = 1; wa0 = 0; wd0 = 32'hFFFF_FFFF; iss_valid = 1; iss_rd = 0;
        step(1, "r0_write_issue");
        idle(); ra2 = 0; step(1, "r0_after");

        idle(); iss_valid = 1; iss_rd = 4; step(1, "issue4");
        idle(); iss_valid = 1; iss_rd = 6; step(1, "issue6");
        idle(); iss_valid = 1; iss_rd = 8; ra1 = 4; step(1, "issue8");
        idle(); reset = 0; ra1 = 6; ra2 = 5; we0 = 1; wa0 = 5; wd0 = 32'h55;
        iss_valid = 1; iss_rd = 3; step(1, "reset_mid");
        idle(); ra1 = 4; ra2 = 7; iss_rd = 8; step(1, "post_reset");

        for (int n = 0; n < 600; n++) begin
            idle();
            reset     = ($urandom_range(0, 59) != 0);
            we0       = $urandom_range(0, 1);
            we1       = $urandom_range(0, 2) == 0;
            wa0       = AW'($urandom_range(0, 9));
            wa1       = AW'($urandom_range(0, 9));
            wd0       = $urandom;
            wd1       = $urandom;
            pc0       = $urandom;
            pc1       = $urandom;
            ra1       = AW'($urandom_range(0, 9));
            ra2       = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 9));
            iss_valid = $urandom_range(0, 1);
            iss_rd    = AW'($urandom_range(0, 9));
            step(1, "random");
        end
        idle();

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_scoreboard.md
GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

Interface
REQ-001 Parameter DW, default 32, data width of each register.
REQ-002 Parameter AW, default 5, address width; register count NREG = 2**AW.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 we0  input  1  write enable, port 0 (early/ALU result).
REQ-006 wa0  input  AW  write address, port 0.
REQ-007 wd0  input  DW  write data, port 0.
REQ-008 pc0  input  32  PC of instruction writing via port 0 (trace only).
REQ-009 we1 / wa1 / wd1 / pc1  input  1/AW/DW/32  write port 1 (late/memory result), same meanings.
REQ-010 ra1, ra2  input  AW  read addresses.
REQ-011 rd1, rd2  output  DW  read data.
REQ-012 busy1, busy2  output  1  pending-write status of ra1 / ra2.
REQ-013 iss_valid  input  1  issuing instruction claims destination iss_rd.
REQ-014 iss_rd  input  AW  destination claimed by issue.
REQ-015 iss_ready  output  1  issue accepted this cycle when iss_valid && iss_ready.
REQ-016 pend_cnt  output  AW+1  registered count of busy registers.

Function
REQ-017 Register 0 SHALL read 0, ignore writes, never be busy; issue to r0 SHALL be accepted with no state change.
REQ-018 A write on port p with wap != 0 SHALL update the register at the next edge.
REQ-019 When both ports write the same nonzero address in one cycle, port 1 SHALL win.
REQ-020 Reads SHALL be combinational with write-through: rdN = wd1 if we1 && wa1 == raN != 0, else wd0 if we0 && wa0 == raN != 0, else stored value.
REQ-021 Scoreboard: one busy bit per register; a write to address a SHALL clear busy[a] at the next edge.
REQ-022 An accepted issue SHALL set busy[iss_rd] at the next edge; if a write to the same address occurs in the same cycle, set SHALL win (final busy = 1).
REQ-023 iss_ready SHALL be 1 unless busy[iss_rd] = 1 and no write to iss_rd occurs this cycle (WAW stall); iss_ready SHALL be 0 while reset is low.
REQ-024 busyN SHALL be 0 when raN is being written this cycle (bypassed), else busy[raN].
REQ-025 pend_cnt SHALL equal popcount of the busy vector after each edge; max value NREG-1.
REQ-026 A write to a non-busy register SHALL update data normally and leave busy unchanged.

Reset
REQ-027 While reset = 0 at an edge: all registers SHALL become 0, all busy bits 0, pend_cnt 0; writes and issues that cycle SHALL be discarded.
REQ-028 While reset = 0, write-through bypass SHALL be suppressed; rd1/rd2 show stored values.
REQ-029 Reset asserted mid-operation with pending writes SHALL clear the scoreboard with no completion required.

Configuration
REQ-030 Macro GRF_TRACE_EN: when defined, each committed write SHALL $display "%d@%h: $%d <= %h" with $time, pcP, waP, wdP, port 0 line first; writes lost to port-1 priority SHALL still print. Undefined: no display, identical RTL behaviour otherwise.

Verification
REQ-031 Reset low 1 cycle, then ra1=3 -> rd1=0, busy1=0, pend_cnt=0, iss_ready=1.
REQ-032 we0=1, wa0=5, wd0=0xA5A5A5A5, ra1=5 same cycle -> rd1=0xA5A5A5A5 combinationally; next cycle stored value matches.
REQ-033 we0/we1 both wa=7, wd0=0x1, wd1=0x2 -> r7=0x2; with GRF_TRACE_EN two lines printed.
REQ-034 Issue rd=9 -> next cycle busy1(ra1=9)=1, pend_cnt=1; re-issue rd=9 -> iss_ready=0; same cycle we1 wa1=9 -> iss_ready=1, busy stays 1, pend_cnt=1.
REQ-035 we0=1, wa0=0, wd0=0xFFFF_FFFF; issue rd=0 -> rd of r0 = 0, pend_cnt unchanged.
REQ-036 Issue rd=4,6,8 on consecutive cycles, reset low on fourth -> all busy cleared, pend_cnt=0, registers 0.
